// File: rtl/fetch_controller_if.sv
// Fetch-side bus: instruction memory port, redirect request and decode handshake.
// The controller is the master; memory/branch unit/decode sit on the slave side.
interface fetch_controller_if;
    logic [7:0] imem_pc;
    logic [7:0] imem_instr;
    logic       redirect_valid;
    logic [7:0] redirect_pc;
    logic       out_valid;
    logic [7:0] out_instr;
    logic [7:0] out_pc;
    logic       out_ready;

    modport master (
        output imem_pc,
        input  imem_instr,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        output out_instr,
        output out_pc,
        input  out_ready
    );

    modport slave (
        input  imem_pc,
        output imem_instr,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        input  out_instr,
        input  out_pc,
        output out_ready
    );
endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, fetches one word per cycle into a
// 2-entry FIFO feeding decode, and handles redirects and halt-on-opcode.
module fetch_controller #(
    parameter logic [7:0] RESET_PC    = 8'h00,
    parameter logic [7:0] HALT_OPCODE = 8'hFF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    fetch_controller_if.master     bus,
    output logic                   busy,
    output logic                   halted
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } state_t;

    typedef struct packed {
        logic [7:0] pc;
        logic [7:0] instr;
    } entry_t;

    state_t     state, state_nxt;
    logic [7:0] pc, pc_nxt;

    entry_t     fifo [2];
    logic       rd_ptr, wr_ptr;
    logic [1:0] count;

    logic       deq, flush, fetch;
    entry_t     head;

    always_comb begin
        deq   = (count != 2'd0) && bus.out_ready;
        flush = bus.redirect_valid && (state != IDLE);
        // A slot frees up this cycle if decode takes the head, so a full FIFO can still fetch.
        fetch = (state == FETCH) && !bus.redirect_valid && ((count != 2'd2) || deq);
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        case (state)
            IDLE: begin
                if (start) state_nxt = FETCH;
            end
            FETCH, HALTED: begin
                if (flush) begin
                    state_nxt = FETCH;
                    pc_nxt    = bus.redirect_pc;
                end else if (fetch) begin
                    pc_nxt = pc + 8'd1;
                    if (bus.imem_instr == HALT_OPCODE) state_nxt = HALTED;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    // Flush wins over a same-cycle pop: the popped head is simply gone with the rest.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count   <= 2'd0;
            fifo[0] <= '0;
            fifo[1] <= '0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (fetch) begin
                fifo[wr_ptr] <= '{pc: pc, instr: bus.imem_instr};
                wr_ptr       <= ~wr_ptr;
            end
            if (deq) rd_ptr <= ~rd_ptr;
            case ({fetch, deq})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        head          = fifo[rd_ptr];
        bus.imem_pc   = pc;
        bus.out_valid = (count != 2'd0);
        bus.out_instr = bus.out_valid ? head.instr : 8'h00;
        bus.out_pc    = bus.out_valid ? head.pc    : 8'h00;
        busy          = (state == FETCH);
        halted        = (state == HALTED) && (count == 2'd0);
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: a queue-based fetch model checked every
// cycle against the DUT, plus literal expectations on key points of each scenario.
module tb_fetch_controller;

    logic clk = 1'b0;
    logic reset, start;
    logic busy, halted;
    fetch_controller_if bus ();

    fetch_controller #(.RESET_PC(8'h00), .HALT_OPCODE(8'hFF)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .bus    (bus),
        .busy   (busy),
        .halted (halted)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    assign bus.imem_instr = mem[bus.imem_pc];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model state: 0 idle, 1 fetching, 2 halted
    int          mmode = 0;
    logic [7:0]  mpc   = 8'h00;
    logic [15:0] mq  [$];
    logic [15:0] mlog[$];

    logic [15:0] exp_run [6] = '{16'h0011, 16'h0122, 16'h0233, 16'h0344, 16'h0414, 16'h05FF};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_log(input string nm);
        chk({nm, "_n"}, mlog.size(), 6);
        for (int i = 0; i < 6 && i < mlog.size(); i++)
            chk(nm, mlog[i], exp_run[i]);
    endtask

    // Compare current outputs, then advance the model by the inputs that the next edge samples.
    always @(negedge clk) begin
        bit         d, can;
        logic [7:0] w;
        if (chk_en) begin
            chk("imem_pc", bus.imem_pc, mpc);
            chk("out_valid", bus.out_valid, mq.size() != 0);
            if (mq.size() != 0) begin
                chk("out_pc", bus.out_pc, mq[0][15:8]);
                chk("out_instr", bus.out_instr, mq[0][7:0]);
            end
            chk("busy", busy, mmode == 1);
            chk("halted", halted, (mmode == 2) && (mq.size() == 0));
        end
        if (reset) begin
            mq.delete();
            mpc   = 8'h00;
            mmode = 0;
        end else begin
            d = (mq.size() != 0) && bus.out_ready;
            if (d) mlog.push_back(mq[0]);
            if (mmode == 0) begin
                if (start) mmode = 1;
            end else if (bus.redirect_valid) begin
                mq.delete();
                mpc   = bus.redirect_pc;
                mmode = 1;
            end else begin
                can = (mmode == 1) && (mq.size() < 2 || d);
                if (d) void'(mq.pop_front());
                if (can) begin
                    w = mem[mpc];
                    mq.push_back({mpc, w});
                    if (w == 8'hFF) mmode = 2;
                    mpc = mpc + 8'd1;
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i + 16);
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
        mem[5] = 8'hFF;

        reset = 1'b1; start = 1'b0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = 8'h00; bus.out_ready = 1'b0;

        // Reset state
        cyc(1);
        chk_en = 1'b1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_instr", bus.out_instr, 0);
        chk("rst_out_pc", bus.out_pc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_imem_pc", bus.imem_pc, 8'h00);
        cyc(1);
        reset = 1'b0;
        cyc(2);
        chk("idle_busy", busy, 0);
        chk("idle_valid", bus.out_valid, 0);

        // Streaming with decode always ready, running into the halt word at 05
        bus.out_ready = 1'b1; start = 1'b1; mlog.delete();
        cyc(1); start = 1'b0;
        chk("lat_valid0", bus.out_valid, 0);
        cyc(1); chk("s0_pc", bus.out_pc, 8'h00); chk("s0_in", bus.out_instr, 8'h11);
        cyc(1); chk("s1_pc", bus.out_pc, 8'h01); chk("s1_in", bus.out_instr, 8'h22);
        cyc(1); chk("s2_pc", bus.out_pc, 8'h02); chk("s2_in", bus.out_instr, 8'h33);
        cyc(1); chk("s3_pc", bus.out_pc, 8'h03); chk("s3_in", bus.out_instr, 8'h44);
        cyc(4);
        chk("halt_halted", halted, 1);
        chk("halt_imem_pc", bus.imem_pc, 8'h06);
        chk("halt_busy", busy, 0);
        chk_log("stream_log");

        // Redirect out of HALTED resumes fetching
        bus.redirect_valid = 1'b1; bus.redirect_pc = 8'h10;
        cyc(1); bus.redirect_valid = 1'b0;
        chk("rh_busy", busy, 1);
        chk("rh_valid", bus.out_valid, 0);
        cyc(1); chk("rh_pc", bus.out_pc, 8'h10); chk("rh_in", bus.out_instr, 8'h20);

        // Redirect with two entries buffered; head accepted in the redirect cycle
        bus.out_ready = 1'b0;
        cyc(2);
        chk("full_imem_pc", bus.imem_pc, 8'h12);
        chk("full_head_pc", bus.out_pc, 8'h10);
        mlog.delete();
        bus.redirect_valid = 1'b1; bus.redirect_pc = 8'h40; bus.out_ready = 1'b1;
        cyc(1); bus.redirect_valid = 1'b0;
        chk("rd_gap_valid", bus.out_valid, 0);
        chk("rd_acc_n", mlog.size(), 1);
        chk("rd_acc", mlog[0], 16'h1020);
        cyc(1);
        chk("rd_valid", bus.out_valid, 1);
        chk("rd_pc", bus.out_pc, 8'h40); chk("rd_in", bus.out_instr, 8'h50);

        // PC wrap, then reset mid-stream
        bus.redirect_valid = 1'b1; bus.redirect_pc = 8'hFE;
        cyc(1); bus.redirect_valid = 1'b0;
        cyc(1); chk("w0_pc", bus.out_pc, 8'hFE); chk("w0_in", bus.out_instr, 8'h0E);
        cyc(1); chk("w1_pc", bus.out_pc, 8'hFF); chk("w1_in", bus.out_instr, 8'h0F);
        cyc(1); chk("w2_pc", bus.out_pc, 8'h00); chk("w2_in", bus.out_instr, 8'h11);
        reset = 1'b1;
        cyc(1); reset = 1'b0;
        chk("mr_busy", busy, 0);
        chk("mr_valid", bus.out_valid, 0);
        chk("mr_imem_pc", bus.imem_pc, 8'h00);

        // Backpressure from the first fetch, then release with no loss or duplication
        bus.out_ready = 1'b0; start = 1'b1;
        cyc(1); start = 1'b0;
        cyc(4);
        chk("bp_imem_pc", bus.imem_pc, 8'h02);
        chk("bp_valid", bus.out_valid, 1);
        chk("bp_pc", bus.out_pc, 8'h00); chk("bp_in", bus.out_instr, 8'h11);
        mlog.delete();
        bus.out_ready = 1'b1;
        cyc(8);
        chk_log("bp_log");
        chk("bp_halted", halted, 1);

        // Redirect in the same cycle the halt word is on the memory bus
        bus.redirect_valid = 1'b1; bus.redirect_pc = 8'h04;
        cyc(1); bus.redirect_valid = 1'b0;
        cyc(1);
        chk("rb_imem_instr", bus.imem_instr, 8'hFF);
        bus.redirect_valid = 1'b1; bus.redirect_pc = 8'h20;
        cyc(1); bus.redirect_valid = 1'b0;
        chk("rb_busy", busy, 1);
        chk("rb_halted", halted, 0);
        cyc(1); chk("rb_pc", bus.out_pc, 8'h20); chk("rb_in", bus.out_instr, 8'h30);
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
